// File: rtl/pe_array_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pe_array_pkg
//  Description : Shared types and helpers for the PE array pass sequencer.
//                Holds the scheduler state encoding, the psum latency
//                function and the lane-packing helpers.
//  Revision    : 1.0  initial release
// ============================================================================
package pe_array_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        ISSUE = 3'd2,
        WAIT  = 3'd3,
        DRAIN = 3'd4,
        DONE  = 3'd5
    } sched_state_t;

    // Cycles from the issue cycle to the cycle where psum is valid at the array edge
    function automatic int lat_cycles(input int num_rows, input int delay_cycles);
        return num_rows * delay_cycles;
    endfunction

    // Counter width able to hold LAT-1; never narrower than one bit
    function automatic int cnt_width(input int lat);
        return (lat <= 2) ? 1 : $clog2(lat);
    endfunction

    // LSB position of lane k in a packed bus of lanes of the given width
    function automatic int lane_lsb(input int lane, input int width);
        return lane * width;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sched_delay_cnt.sv
`default_nettype none
// ============================================================================
//  Module      : sched_delay_cnt
//  Description : Loadable down-counter that stops at zero and flags it.
//                Times the psum latency between issue and capture.
//  Revision    : 1.0  initial release
// ============================================================================
module sched_delay_cnt #(
    parameter int WIDTH = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    output logic [WIDTH-1:0] count,
    output logic             zero
);

    // Load has priority; otherwise count down while enabled, saturating at zero
    always_ff @(posedge clk) begin
        if (!rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule
`default_nettype wire

// File: rtl/pe_array_sched.sv
`default_nettype none
// ============================================================================
//  Module      : pe_array_sched
//  Description : Pass-sequencing controller for the dummy PE array. Accepts a
//                job, fetches one ifmap vector per pass, issues it for a single
//                cycle, waits out the psum latency and returns the captured
//                psum row over a valid/ready port. One vector in flight at most.
//  Revision    : 1.0  initial release
// ============================================================================
module pe_array_sched
    import pe_array_pkg::*;
#(
    parameter int DELAY_CYCLES = 10,
    parameter int PE_WIDTH     = 4,
    parameter int NUM_ROWS     = 3,
    parameter int NUM_COLS     = 3,
    parameter int PASS_W       = 8
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           cfg_valid,
    output logic                           cfg_ready,
    input  logic [NUM_ROWS-2:0]            cfg_sel,
    input  logic [PASS_W-1:0]              cfg_passes,
    output logic                           buf_rd_en,
    input  logic                           buf_rd_valid,
    input  logic [NUM_ROWS*PE_WIDTH-1:0]   buf_col_data,
    input  logic [(NUM_COLS-1)*PE_WIDTH-1:0] buf_row_data,
    output logic [NUM_ROWS*PE_WIDTH-1:0]   arr_col_in,
    output logic [(NUM_COLS-1)*PE_WIDTH-1:0] arr_row_in,
    output logic [NUM_ROWS-2:0]            arr_sel,
    input  logic [NUM_COLS*PE_WIDTH-1:0]   arr_psum,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [NUM_COLS*PE_WIDTH-1:0]   out_psum,
    output logic                           busy,
    output logic                           done
);

    localparam int LAT   = lat_cycles(NUM_ROWS, DELAY_CYCLES);
    localparam int CNT_W = cnt_width(LAT);
    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(LAT - 1);

    sched_state_t                    r_state;
    sched_state_t                    w_state_nxt;
    logic [PASS_W-1:0]               r_passes;
    logic [NUM_ROWS-2:0]             r_sel;
    logic [NUM_ROWS*PE_WIDTH-1:0]    r_col;
    logic [(NUM_COLS-1)*PE_WIDTH-1:0] r_row;
    logic [NUM_COLS*PE_WIDTH-1:0]    r_psum;
    logic [CNT_W-1:0]                w_cnt;
    logic                            w_cnt_zero;
    logic                            w_accept;
    logic                            w_handshake;

    assign w_accept    = (r_state == IDLE)  && cfg_valid;
    assign w_handshake = (r_state == DRAIN) && out_ready;

    // Latency timer: loaded on the issue cycle so WAIT spans exactly LAT cycles
    sched_delay_cnt #(
        .WIDTH (CNT_W)
    ) u_delay_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (r_state == ISSUE),
        .load_val (LOAD_VAL),
        .en       (r_state == WAIT),
        .count    (w_cnt),
        .zero     (w_cnt_zero)
    );

    // State register
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; r_passes counts the current pass, so 1 means last
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (cfg_valid)    w_state_nxt = (cfg_passes == '0) ? DONE : FETCH;
            FETCH:   if (buf_rd_valid) w_state_nxt = ISSUE;
            ISSUE:                     w_state_nxt = WAIT;
            WAIT:    if (w_cnt_zero)   w_state_nxt = DRAIN;
            DRAIN:   if (out_ready)    w_state_nxt = (r_passes == PASS_W'(1)) ? DONE : FETCH;
            DONE:                      w_state_nxt = IDLE;
            default:                   w_state_nxt = IDLE;
        endcase
    end

    // Job and datapath registers: sel/pass latch, one-cycle issue vector, psum capture
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_passes <= '0;
            r_sel    <= '0;
            r_col    <= '0;
            r_row    <= '0;
            r_psum   <= '0;
        end else begin
            if (w_accept) begin
                r_passes <= cfg_passes;
                r_sel    <= cfg_sel;
            end else if (w_handshake) begin
                r_passes <= r_passes - 1'b1;
            end else if (r_state == DONE) begin
                r_sel    <= '0;
            end
            // Edge data is non-zero only during ISSUE
            if ((r_state == FETCH) && buf_rd_valid) begin
                r_col <= buf_col_data;
                r_row <= buf_row_data;
            end else begin
                r_col <= '0;
                r_row <= '0;
            end
            if ((r_state == WAIT) && w_cnt_zero) begin
                r_psum <= arr_psum;
            end
        end
    end

    // Outputs decoded from the registered state
    always_comb begin
        cfg_ready = (r_state == IDLE);
        buf_rd_en = (r_state == FETCH);
        out_valid = (r_state == DRAIN);
        busy      = (r_state != IDLE);
        done      = (r_state == DONE);
    end

    assign arr_col_in = r_col;
    assign arr_row_in = r_row;
    assign arr_sel    = r_sel;
    assign out_psum   = r_psum;

endmodule
`default_nettype wire

// File: tb/tb_pe_array_sched.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pe_array_sched
//  Description : Directed self-checking bench for pe_array_sched with a
//                delay-line array model and a simple buffer responder.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_pe_array_sched;

    localparam int DELAY_CYCLES = 10;
    localparam int PE_WIDTH     = 4;
    localparam int NUM_ROWS     = 3;
    localparam int NUM_COLS     = 3;
    localparam int PASS_W       = 8;
    localparam int LAT          = NUM_ROWS * DELAY_CYCLES;
    localparam int COL_W        = NUM_ROWS * PE_WIDTH;
    localparam int ROW_W        = (NUM_COLS - 1) * PE_WIDTH;
    localparam int PSUM_W       = NUM_COLS * PE_WIDTH;

    logic                clk = 1'b0;
    logic                rst = 1'b0;
    logic                cfg_valid = 1'b0;
    logic                cfg_ready;
    logic [NUM_ROWS-2:0] cfg_sel = '0;
    logic [PASS_W-1:0]   cfg_passes = '0;
    logic                buf_rd_en;
    logic                buf_rd_valid = 1'b0;
    logic [COL_W-1:0]    buf_col_data = '0;
    logic [ROW_W-1:0]    buf_row_data = '0;
    logic [COL_W-1:0]    arr_col_in;
    logic [ROW_W-1:0]    arr_row_in;
    logic [NUM_ROWS-2:0] arr_sel;
    logic [PSUM_W-1:0]   arr_psum;
    logic                out_valid;
    logic                out_ready = 1'b0;
    logic [PSUM_W-1:0]   out_psum;
    logic                busy;
    logic                done;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pe_array_sched #(
        .DELAY_CYCLES (DELAY_CYCLES),
        .PE_WIDTH     (PE_WIDTH),
        .NUM_ROWS     (NUM_ROWS),
        .NUM_COLS     (NUM_COLS),
        .PASS_W       (PASS_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .cfg_valid    (cfg_valid),
        .cfg_ready    (cfg_ready),
        .cfg_sel      (cfg_sel),
        .cfg_passes   (cfg_passes),
        .buf_rd_en    (buf_rd_en),
        .buf_rd_valid (buf_rd_valid),
        .buf_col_data (buf_col_data),
        .buf_row_data (buf_row_data),
        .arr_col_in   (arr_col_in),
        .arr_row_in   (arr_row_in),
        .arr_sel      (arr_sel),
        .arr_psum     (arr_psum),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_psum     (out_psum),
        .busy         (busy),
        .done         (done)
    );

    // Array model: the issued vector emerges LAT cycles after its issue cycle
    logic [COL_W+ROW_W-1:0] dline [LAT];
    always @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < LAT; i++) dline[i] <= '0;
        end else begin
            dline[0] <= {arr_row_in, arr_col_in};
            for (int i = 1; i < LAT; i++) dline[i] <= dline[i-1];
        end
    end

    // psum lane0 = sum(col)+sel; lane j>0 adds row lane j-1 (all mod 16)
    logic [COL_W+ROW_W-1:0] tap;
    logic [PE_WIDTH-1:0]    lane_sum;
    always_comb begin
        tap      = dline[LAT-1];
        lane_sum = tap[3:0] + tap[7:4] + tap[11:8] + {2'b00, arr_sel};
        arr_psum = {lane_sum + tap[19:16], lane_sum + tap[15:12], lane_sum};
    end

    // Waits for buf_rd_en, answers after dly cycles; returns at the ISSUE negedge
    task automatic serve_fetch(input int dly, input logic [COL_W-1:0] col, input logic [ROW_W-1:0] row);
        int n;
        n = 0;
        while (buf_rd_en !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        n_cmp++;
        if (buf_rd_en !== 1'b1) begin
            n_err++;
            $display("FAIL fetch_timeout: buf_rd_en=%b after %0d cycles, required 1", buf_rd_en, n);
        end
        repeat (dly) @(negedge clk);
        buf_rd_valid = 1'b1;
        buf_col_data = col;
        buf_row_data = row;
        @(negedge clk);
        buf_rd_valid = 1'b0;
        buf_col_data = 12'hA5A;
        buf_row_data = 8'h5A;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (out_valid !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic test_reset;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (cfg_ready !== 1'b1) begin n_err++; $display("FAIL reset_cfg_ready: got %b, required 1", cfg_ready); end
        n_cmp++;
        if ({busy, done, out_valid, buf_rd_en} !== 4'b0000) begin
            n_err++; $display("FAIL reset_flags: busy/done/out_valid/buf_rd_en=%b, required 0000", {busy, done, out_valid, buf_rd_en});
        end
        n_cmp++;
        if ({arr_col_in, arr_row_in, arr_sel, out_psum} !== '0) begin
            n_err++; $display("FAIL reset_data: col=%h row=%h sel=%b psum=%h, required all 0", arr_col_in, arr_row_in, arr_sel, out_psum);
        end
        rst = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({cfg_ready, busy} !== 2'b10) begin n_err++; $display("FAIL reset_release: cfg_ready/busy=%b, required 10", {cfg_ready, busy}); end
    endtask

    task automatic test_single_pass;
        int n;
        int nz;
        cfg_valid = 1'b1; cfg_passes = 8'd1; cfg_sel = 2'b01;
        @(negedge clk);
        cfg_valid = 1'b0; cfg_passes = '0; cfg_sel = '0;
        n_cmp++;
        if ({arr_sel, buf_rd_en, cfg_ready, busy} !== 5'b01_1_0_1) begin
            n_err++; $display("FAIL single_fetch: sel/rd_en/cfg_ready/busy=%b, required 01101", {arr_sel, buf_rd_en, cfg_ready, busy});
        end
        serve_fetch(1, 12'h321, 8'h54);
        n_cmp++;
        if ({arr_col_in, arr_row_in} !== {12'h321, 8'h54}) begin
            n_err++; $display("FAIL single_issue: col=%h row=%h, required 321 54", arr_col_in, arr_row_in);
        end
        nz = 1; n = 0;
        while (out_valid !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
            if (arr_col_in != '0 || arr_row_in != '0) nz++;
        end
        n_cmp++;
        if (n != LAT + 1) begin n_err++; $display("FAIL single_latency: out_valid after %0d cycles, required %0d", n, LAT + 1); end
        n_cmp++;
        if (nz != 1) begin n_err++; $display("FAIL single_issue_width: edge data non-zero %0d cycles, required 1", nz); end
        n_cmp++;
        if (out_psum !== 12'hCB7) begin n_err++; $display("FAIL single_psum: got %h, required cb7", out_psum); end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        n_cmp++;
        if ({done, out_valid, arr_sel, buf_rd_en} !== 5'b1_0_01_0) begin
            n_err++; $display("FAIL single_done: done/out_valid/sel/rd_en=%b, required 10010", {done, out_valid, arr_sel, buf_rd_en});
        end
        @(negedge clk);
        n_cmp++;
        if ({done, cfg_ready, arr_sel, busy} !== 5'b0_1_00_0) begin
            n_err++; $display("FAIL single_idle: done/cfg_ready/sel/busy=%b, required 01000", {done, cfg_ready, arr_sel, busy});
        end
    endtask

    task automatic test_zero_passes;
        cfg_valid = 1'b1; cfg_passes = 8'd0; cfg_sel = 2'b10;
        @(negedge clk);
        cfg_valid = 1'b0; cfg_sel = '0;
        n_cmp++;
        if ({done, arr_sel, buf_rd_en, busy} !== 5'b1_10_0_1) begin
            n_err++; $display("FAIL zero_done: done/sel/rd_en/busy=%b, required 11001", {done, arr_sel, buf_rd_en, busy});
        end
        @(negedge clk);
        n_cmp++;
        if ({done, cfg_ready, buf_rd_en} !== 3'b010) begin
            n_err++; $display("FAIL zero_idle: done/cfg_ready/rd_en=%b, required 010", {done, cfg_ready, buf_rd_en});
        end
        buf_rd_valid = 1'b1; buf_col_data = 12'hFFF; buf_row_data = 8'hFF;
        @(negedge clk);
        buf_rd_valid = 1'b0;
        n_cmp++;
        if ({arr_col_in, arr_row_in, busy} !== '0) begin
            n_err++; $display("FAIL stray_buffer: col=%h row=%h busy=%b, required 0 0 0", arr_col_in, arr_row_in, busy);
        end
    endtask

    task automatic test_backpressure;
        int n;
        cfg_valid = 1'b1; cfg_passes = 8'd1; cfg_sel = 2'b11;
        @(negedge clk);
        cfg_valid = 1'b0; cfg_sel = '0;
        serve_fetch(0, 12'h001, 8'h00);
        wait_valid(n);
        n_cmp++;
        if ({out_valid, out_psum} !== {1'b1, 12'h444}) begin
            n_err++; $display("FAIL bp_first: valid=%b psum=%h, required 1 444", out_valid, out_psum);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_cmp++;
            if ({out_valid, out_psum, buf_rd_en, done} !== {1'b1, 12'h444, 1'b0, 1'b0}) begin
                n_err++; $display("FAIL bp_hold%0d: valid=%b psum=%h rd_en=%b done=%b, required 1 444 0 0", i, out_valid, out_psum, buf_rd_en, done);
            end
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        n_cmp++;
        if ({done, out_valid, buf_rd_en} !== 3'b100) begin
            n_err++; $display("FAIL bp_done: done/valid/rd_en=%b, required 100", {done, out_valid, buf_rd_en});
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back;
        int                 n;
        int                 dly   [3] = '{0, 2, 4};
        logic [COL_W-1:0]   col_v [3] = '{12'h111, 12'h432, 12'hFFF};
        logic [ROW_W-1:0]   row_v [3] = '{8'h00, 8'h12, 8'hFF};
        logic [PSUM_W-1:0]  exp_v [3] = '{12'h555, 12'hCDB, 12'hEEF};
        cfg_valid = 1'b1; cfg_passes = 8'd3; cfg_sel = 2'b10;
        @(negedge clk);
        cfg_valid = 1'b0; cfg_passes = '0; cfg_sel = '0;
        for (int i = 0; i < 3; i++) begin
            serve_fetch(dly[i], col_v[i], row_v[i]);
            if (i == 0) begin
                repeat (5) @(negedge clk);
                cfg_valid = 1'b1; cfg_sel = 2'b01; cfg_passes = 8'd7;
                n_cmp++;
                if (cfg_ready !== 1'b0) begin n_err++; $display("FAIL b2b_cfg_ready: got %b, required 0", cfg_ready); end
                @(negedge clk);
                cfg_valid = 1'b0; cfg_sel = '0; cfg_passes = '0;
                n_cmp++;
                if ({arr_sel, busy} !== 3'b10_1) begin
                    n_err++; $display("FAIL b2b_sel_kept: sel/busy=%b, required 101", {arr_sel, busy});
                end
            end
            wait_valid(n);
            n_cmp++;
            if ({out_valid, out_psum} !== {1'b1, exp_v[i]}) begin
                n_err++; $display("FAIL b2b_psum%0d: valid=%b psum=%h, required 1 %h", i, out_valid, out_psum, exp_v[i]);
            end
            if (i > 0) begin
                n_cmp++;
                if (n != LAT + 1) begin n_err++; $display("FAIL b2b_latency%0d: %0d cycles, required %0d", i, n, LAT + 1); end
            end
            out_ready = 1'b1;
            @(negedge clk);
            out_ready = 1'b0;
            n_cmp++;
            if (i < 2) begin
                if ({buf_rd_en, done} !== 2'b10) begin
                    n_err++; $display("FAIL b2b_next%0d: rd_en/done=%b, required 10", i, {buf_rd_en, done});
                end
            end else begin
                if ({buf_rd_en, done} !== 2'b01) begin
                    n_err++; $display("FAIL b2b_end: rd_en/done=%b, required 01", {buf_rd_en, done});
                end
            end
        end
        @(negedge clk);
        n_cmp++;
        if ({cfg_ready, arr_sel} !== 3'b1_00) begin
            n_err++; $display("FAIL b2b_idle: cfg_ready/sel=%b, required 100", {cfg_ready, arr_sel});
        end
    endtask

    task automatic test_reset_mid_wait;
        int n;
        int bad;
        cfg_valid = 1'b1; cfg_passes = 8'd2; cfg_sel = 2'b01;
        @(negedge clk);
        cfg_valid = 1'b0; cfg_passes = '0; cfg_sel = '0;
        serve_fetch(0, 12'h321, 8'h54);
        repeat (10) @(negedge clk);
        n_cmp++;
        if ({busy, out_valid} !== 2'b10) begin n_err++; $display("FAIL mid_wait_state: busy/valid=%b, required 10", {busy, out_valid}); end
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        n_cmp++;
        if ({cfg_ready, busy, out_valid, arr_sel, done, out_psum} !== {1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 12'h000}) begin
            n_err++; $display("FAIL mid_reset: cfg_ready=%b busy=%b valid=%b sel=%b done=%b psum=%h, required 1 0 0 00 0 000",
                              cfg_ready, busy, out_valid, arr_sel, done, out_psum);
        end
        bad = 0;
        for (int i = 0; i < LAT + 10; i++) begin
            @(negedge clk);
            if (done || out_valid || buf_rd_en || busy) bad++;
        end
        n_cmp++;
        if (bad != 0) begin n_err++; $display("FAIL mid_reset_quiet: %0d active cycles after reset, required 0", bad); end
        cfg_valid = 1'b1; cfg_passes = 8'd1; cfg_sel = 2'b01;
        @(negedge clk);
        cfg_valid = 1'b0; cfg_passes = '0; cfg_sel = '0;
        serve_fetch(0, 12'h222, 8'h11);
        wait_valid(n);
        n_cmp++;
        if ({out_valid, out_psum} !== {1'b1, 12'h887} || n != LAT + 1) begin
            n_err++; $display("FAIL after_reset_psum: valid=%b psum=%h after %0d cycles, required 1 887 after %0d", out_valid, out_psum, n, LAT + 1);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        n_cmp++;
        if (done !== 1'b1) begin n_err++; $display("FAIL after_reset_done: got %b, required 1", done); end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_single_pass();
        test_zero_passes();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_wait();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
